// File: rtl/pc_disp_pkg.sv
// Shared constants for the PC decimal display.
// Segment codes are active-low, bits [6:0] = a..g.
package pc_disp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Index 9 first, index 0 last.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0000100,
        7'b0000000,
        7'b0001111,
        7'b0100000,
        7'b0100100,
        7'b1001100,
        7'b0000110,
        7'b0010010,
        7'b1001111,
        7'b0000001
    };

endpackage

// File: rtl/pc_bcd_display_seg7_enc.sv
// BCD nibble to active-low 7-segment code.
// Nibbles above 9 and forced blanks both render as blank.
import pc_disp_pkg::*;

module seg7_enc (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_BLANK;
        if (!blank && nib <= 4'd9)
            code = SEG_DIGIT[nib];
    end

endmodule

// File: rtl/pc_bcd_display.sv
// Sequential shift-and-add-3 PC word-index to 7-segment display.
// Define PC_DISP_LZ_BLANK_EN to blank leading zero digits.
import pc_disp_pkg::*;

module pc_bcd_display #(
    parameter int WORD_W = 32,
    parameter int SHIFT  = 2,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   pc,
    input  logic                update,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [7*DIGITS-1:0] seg
);

    localparam int N  = WORD_W - SHIFT;
    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;

    state_t              state;
    logic [N-1:0]        bin;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt;
    logic                ovf_int;
    logic                pending;
    logic [DIGITS-1:0]   blank;
    logic [7*DIGITS-1:0] enc;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef PC_DISP_LZ_BLANK_EN
    logic seen_nz;

    // Walk from the top digit down; blank until a non-zero digit appears.
    always_comb begin
        seen_nz = 1'b0;
        blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz  = seen_nz | (|bcd[4*i +: 4]);
            blank[i] = (i != 0) && !seen_nz;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        seg7_enc u_enc (
            .nib   (bcd[4*i +: 4]),
            .blank (blank[i]),
            .code  (enc[7*i +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            seg     <= {DIGITS{SEG_BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (update) begin
                        bin     <= pc[WORD_W-1:SHIFT];
                        bcd     <= '0;
                        cnt     <= '0;
                        ovf_int <= 1'b0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (update)
                        pending <= 1'b1;
                    {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
                    ovf_int    <= ovf_int | bcd_adj[BW-1];
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    seg  <= ovf_int ? {DIGITS{SEG_DASH}} : enc;
                    ovf  <= ovf_int;
                    done <= 1'b1;
                    // A request arriving on this edge is folded into the reload.
                    if (pending || update) begin
                        bin     <= pc[WORD_W-1:SHIFT];
                        bcd     <= '0;
                        cnt     <= '0;
                        ovf_int <= 1'b0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_bcd_display.sv
// Randomised self-checking bench for pc_bcd_display.
// Expected digits come from decimal arithmetic on the word index.
module tb_pc_bcd_display;

    localparam int W  = 32;
    localparam int SH = 2;
    localparam int D  = 2;
    localparam int N  = W - SH;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   pc;
    logic           update;
    logic           busy;
    logic           done;
    logic           ovf;
    logic [7*D-1:0] seg;

    int checks   = 0;
    int failures = 0;

    logic [7*D-1:0] prev_seg;
    logic           prev_ovf;

    pc_bcd_display #(.WORD_W(W), .SHIFT(SH), .DIGITS(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc     (pc),
        .update (update),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dig7(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic longint lim_val();
        longint l = 1;
        for (int i = 0; i < D; i++) l = l * 10;
        return l;
    endfunction

    function automatic logic [7*D-1:0] model_seg(input longint v);
        logic [7*D-1:0] s;
        longint p = 1;
        s = '0;
        if (v >= lim_val()) begin
            for (int i = 0; i < D; i++) s[7*i +: 7] = 7'b1111110;
            return s;
        end
        for (int i = 0; i < D; i++) begin
            s[7*i +: 7] = dig7(int'((v / p) % 10));
`ifdef PC_DISP_LZ_BLANK_EN
            if (i > 0 && v < p) s[7*i +: 7] = 7'h7F;
`endif
            p = p * 10;
        end
        return s;
    endfunction

    task automatic run_conv(input logic [W-1:0] p, input string tag);
        longint v = longint'(p >> SH);
        int busy_cnt = 0;
        int got_k = -1;
        @(negedge clk);
        pc = p;
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
        for (int k = 0; k < N + 10; k++) begin
            if (k == 5) begin
                chk({tag, "_hold_seg"}, seg, prev_seg);
                chk({tag, "_hold_ovf"}, ovf, prev_ovf);
            end
            if (done) begin
                got_k = k;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, got_k, N + 1);
        chk({tag, "_busy_cycles"}, busy_cnt, N);
        chk({tag, "_seg"}, seg, model_seg(v));
        chk({tag, "_ovf"}, ovf, v >= lim_val());
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        prev_seg = model_seg(v);
        prev_ovf = v >= lim_val();
    endtask

    initial begin
        int dones;
        int first_k;
        logic [W-1:0] rp;

        rst = 1'b1;
        update = 1'b0;
        pc = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, {D{7'h7F}});
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        prev_seg = {D{7'h7F}};
        prev_ovf = 1'b0;

        run_conv(32'h28, "ten");
        run_conv(32'h18C, "n99");
        run_conv(32'h190, "n100");

        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                rp = $urandom;
            else if (i % 2 == 1)
                rp = {22'd0, 8'($urandom_range(0, 130)), 2'($urandom_range(0, 3))};
            else
                rp = 32'($urandom_range(0, 110)) * 4;
            run_conv(rp, "rand");
        end

        // Several requests while busy collapse to one reload of the late pc.
        @(negedge clk);
        pc = 32'h100;
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
        dones = 0;
        first_k = 0;
        for (int k = 0; k < 3 * N; k++) begin
            update = (k == 3 || k == 7 || k == 12);
            if (k == 10) pc = 32'h14;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_k = k;
                    chk("pend_first_seg", seg, model_seg(64));
                    chk("pend_restart_busy", busy, 1'b1);
                end else begin
                    chk("pend_second_seg", seg, model_seg(5));
                    chk("pend_second_gap", k - first_k, N + 1);
                end
            end
            @(negedge clk);
        end
        update = 1'b0;
        chk("pend_done_count", dones, 2);
        prev_seg = model_seg(5);
        prev_ovf = 1'b0;

        run_conv(32'h190, "pre_rst");

        // Reset mid-conversion with a request queued.
        @(negedge clk);
        pc = 32'h28;
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
        repeat (4) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_seg", seg, {D{7'h7F}});
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        first_k = 0;
        for (int k = 0; k < 2 * N; k++) begin
            if (done) dones++;
            if (busy) first_k++;
            @(negedge clk);
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_no_busy", first_k, 0);
        prev_seg = {D{7'h7F}};
        prev_ovf = 1'b0;

        run_conv(32'h1C, "seven");
        run_conv(32'h0, "zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
